// File: rtl/pio_out_driver.sv
// pio_out_driver: Avalon-MM master for a single-channel output PIO slave.
// Converts each accepted valid/ready command into exactly one bus transaction,
// returns a one-cycle response and keeps a shadow of the expected PIO output.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i         command request
//   cmd_ready_o         command accepted when high (IDLE only)
//   cmd_op_i            0 WRITE, 1 SET, 2 CLEAR, 3 READ
//   cmd_data_i          data for WRITE
//   rsp_valid_o         one-cycle completion pulse
//   rsp_data_o          read data for READ, 0 otherwise; held until next response
//   rsp_mismatch_o      with rsp_valid_o: READ data differed from the old shadow
//   shadow_o            expected PIO output value
//   m_address_o, m_chipselect_o, m_write_n_o, m_writedata_o, m_readdata_i
//                       Avalon-MM master signals (map: 0 data, 4 set, 5 clear)
module pio_out_driver #(
    parameter int unsigned DATA_W       = 1,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_mismatch_o,
    output logic [DATA_W-1:0] shadow_o,
    output logic [2:0]        m_address_o,
    output logic              m_chipselect_o,
    output logic              m_write_n_o,
    output logic [DATA_W-1:0] m_writedata_o,
    input  logic [DATA_W-1:0] m_readdata_i
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               mismatch_q, mismatch_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [2:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               write_n_q, write_n_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               enter_resp;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            data_q      <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mismatch_q  <= 1'b0;
            shadow_q    <= '0;
            addr_q      <= 3'd0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mismatch_q  <= mismatch_d;
            shadow_q    <= shadow_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        shadow_d   = shadow_q;
        mismatch_d = 1'b0;
        // Bus defaults to idle, so it is only active in the cycle after accept
        addr_d     = 3'd0;
        cs_d       = 1'b0;
        write_n_d  = 1'b1;
        wdata_d    = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = op_e'(cmd_op_i);
                    data_d  = cmd_data_i;
                    state_d = ISSUE;
                    cs_d    = 1'b1;
                    case (op_e'(cmd_op_i))
                        OP_WRITE: begin
                            write_n_d = 1'b0;
                            wdata_d   = cmd_data_i;
                        end
                        OP_SET: begin
                            addr_d    = 3'd4;
                            write_n_d = 1'b0;
                            wdata_d   = DATA_W'(1);
                        end
                        OP_CLEAR: begin
                            addr_d    = 3'd5;
                            write_n_d = 1'b0;
                            wdata_d   = DATA_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                if (op_q == OP_READ && READ_LATENCY != 0) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data is sampled on the edge that enters RESP
        enter_resp = (state_d == RESP) && (state_q != RESP);
        if (enter_resp) begin
            rsp_data_d = '0;
            case (op_q)
                OP_WRITE: shadow_d = data_q;
                OP_SET:   shadow_d = DATA_W'(1);
                OP_CLEAR: shadow_d = '0;
                default: begin
                    rsp_data_d = m_readdata_i;
                    mismatch_d = (m_readdata_i != shadow_q);
                    shadow_d   = m_readdata_i;
                end
            endcase
        end

        ready_d     = (state_d == IDLE);
        rsp_valid_d = enter_resp;
    end

    assign cmd_ready_o    = ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_mismatch_o = mismatch_q;
    assign shadow_o       = shadow_q;
    assign m_address_o    = addr_q;
    assign m_chipselect_o = cs_q;
    assign m_write_n_o    = write_n_q;
    assign m_writedata_o  = wdata_q;

endmodule

// File: tb/tb_pio_out_driver.sv
// Bench for pio_out_driver: three instances (read latency 0, 2, 3), each on its
// own PIO slave model, checked every cycle against a timeline model plus
// directed literal expectations.
module tb_pio_out_driver;

    localparam int unsigned DW = 1;
    localparam int NI = 3;
    localparam logic [1:0] OP_W = 2'd0, OP_S = 2'd1, OP_C = 2'd2, OP_R = 2'd3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic [2:0] addr_of(input logic [1:0] op);
        return (op == OP_S) ? 3'd4 : ((op == OP_C) ? 3'd5 : 3'd0);
    endfunction

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          cmd_valid [NI];
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          cmd_ready [NI];
    logic          rsp_valid [NI];
    logic [DW-1:0] rsp_data [NI];
    logic          rsp_mis [NI];
    logic [DW-1:0] shadow [NI];
    logic [2:0]    addr [NI];
    logic          cs [NI];
    logic          wn [NI];
    logic [DW-1:0] wd [NI];
    logic          ovr_en [NI];
    logic [DW-1:0] ovr_val [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW-1:0] pio_q;
        logic [DW-1:0] rd;
        assign rd = ovr_en[g] ? ovr_val[g] : pio_q;

        pio_out_driver #(
            .DATA_W(DW),
            .READ_LATENCY((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .cmd_valid_i   (cmd_valid[g]),
            .cmd_ready_o   (cmd_ready[g]),
            .cmd_op_i      (cmd_op),
            .cmd_data_i    (cmd_data),
            .rsp_valid_o   (rsp_valid[g]),
            .rsp_data_o    (rsp_data[g]),
            .rsp_mismatch_o(rsp_mis[g]),
            .shadow_o      (shadow[g]),
            .m_address_o   (addr[g]),
            .m_chipselect_o(cs[g]),
            .m_write_n_o   (wn[g]),
            .m_writedata_o (wd[g]),
            .m_readdata_i  (rd)
        );

        // Output PIO slave: data / set / clear registers
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) pio_q <= '0;
            else if (cs[g] && !wn[g]) begin
                case (addr[g])
                    3'd0: pio_q <= wd[g];
                    3'd4: pio_q <= pio_q | wd[g];
                    3'd5: pio_q <= pio_q & ~wd[g];
                    default: ;
                endcase
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // Timeline model: ph = cycles since acceptance (0 = idle)
    int            ph [NI];
    logic [1:0]    mop [NI];
    logic [DW-1:0] mdat [NI];
    logic [DW-1:0] m_pio [NI];
    logic [DW-1:0] e_sh [NI];
    logic [DW-1:0] e_rd [NI];
    logic          e_mis [NI];
    int            m_lat, m_rsp;
    logic [DW-1:0] m_smp, m_wd;

    initial begin
        for (int k = 0; k < NI; k++) begin
            ph[k] = 0; mop[k] = OP_W; mdat[k] = '0; m_pio[k] = '0;
            e_sh[k] = '0; e_rd[k] = '0; e_mis[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!reset_n) begin
                ph[k] = 0; m_pio[k] = '0; e_sh[k] = '0; e_rd[k] = '0; e_mis[k] = 1'b0;
            end
            m_lat = lat_of(k);
            m_rsp = (mop[k] == OP_R) ? 2 + m_lat : 2;
            m_wd  = (mop[k] == OP_W) ? mdat[k] : ((mop[k] == OP_R) ? '0 : DW'(1));
            chk("cmd_ready", k, 32'(cmd_ready[k]), 32'(ph[k] == 0));
            chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(ph[k] != 0 && ph[k] == m_rsp));
            chk("rsp_data", k, 32'(rsp_data[k]), 32'(e_rd[k]));
            chk("rsp_mismatch", k, 32'(rsp_mis[k]), 32'(e_mis[k]));
            chk("shadow", k, 32'(shadow[k]), 32'(e_sh[k]));
            chk("chipselect", k, 32'(cs[k]), 32'(ph[k] == 1));
            chk("address", k, 32'(addr[k]), 32'((ph[k] == 1) ? addr_of(mop[k]) : 3'd0));
            chk("write_n", k, 32'(wn[k]), 32'(!(ph[k] == 1 && mop[k] != OP_R)));
            chk("writedata", k, 32'(wd[k]), 32'((ph[k] == 1) ? m_wd : '0));
            if (ph[k] == 0) begin
                if (reset_n && cmd_valid[k]) begin
                    ph[k] = 1; mop[k] = cmd_op; mdat[k] = cmd_data;
                end
            end else begin
                m_smp = ovr_en[k] ? ovr_val[k] : m_pio[k];
                if (ph[k] == m_rsp - 1) begin
                    e_mis[k] = (mop[k] == OP_R) && (m_smp != e_sh[k]);
                    e_rd[k]  = (mop[k] == OP_R) ? m_smp : '0;
                    case (mop[k])
                        OP_W: e_sh[k] = mdat[k];
                        OP_S: e_sh[k] = DW'(1);
                        OP_C: e_sh[k] = '0;
                        default: e_sh[k] = m_smp;
                    endcase
                end
                if (ph[k] == 1) begin
                    case (mop[k])
                        OP_W: m_pio[k] = mdat[k];
                        OP_S: m_pio[k] = m_pio[k] | DW'(1);
                        OP_C: m_pio[k] = m_pio[k] & ~DW'(1);
                        default: ;
                    endcase
                end
                if (ph[k] == m_rsp) begin
                    e_mis[k] = 1'b0;
                    ph[k] = 0;
                end else begin
                    ph[k] = ph[k] + 1;
                end
            end
        end
    end

    // Waits (bounded) until the held command is accepted; t = accept cycle
    task automatic wait_acc(input int k, output int t);
        int n = 0;
        t = -1;
        while (t < 0 && n < 20) begin
            @(negedge clk);
            if (cmd_ready[k]) t = cyc;
            @(posedge clk);
            n++;
        end
        if (t < 0) begin
            tests++; fails++;
            $display("FAIL accept_timeout[%0d]: got no cmd_ready, required 1 within 20 cycles", k);
            t = cyc;
        end
    endtask

    task automatic issue(input int k, input logic [1:0] op, input logic [DW-1:0] d, output int t);
        @(posedge clk); #1;
        cmd_op = op; cmd_data = d; cmd_valid[k] = 1'b1;
        wait_acc(k, t);
        #1 cmd_valid[k] = 1'b0;
    endtask

    task automatic at_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    int t, t1, t2;

    initial begin
        for (int k = 0; k < NI; k++) begin
            cmd_valid[k] = 1'b0; ovr_en[k] = 1'b0; ovr_val[k] = '0;
        end
        cmd_op = OP_W; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 0, 32'(cmd_ready[0]), 32'd1);
        chk("rst_shadow", 0, 32'(shadow[0]), 32'd0);
        chk("rst_cs", 0, 32'(cs[0]), 32'd0);
        chk("rst_write_n", 0, 32'(wn[0]), 32'd1);

        // WRITE 1
        issue(0, OP_W, 1'b1, t);
        at_cyc(t + 1);
        chk("wr_addr", 0, 32'(addr[0]), 32'd0);
        chk("wr_write_n", 0, 32'(wn[0]), 32'd0);
        chk("wr_wdata", 0, 32'(wd[0]), 32'd1);
        at_cyc(t + 2);
        chk("wr_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
        chk("wr_shadow", 0, 32'(shadow[0]), 32'd1);

        // SET then CLEAR with cmd_valid held high
        @(posedge clk); #1;
        cmd_op = OP_S; cmd_data = '0; cmd_valid[0] = 1'b1;
        wait_acc(0, t1);
        #1 cmd_op = OP_C;
        @(negedge clk);
        chk("set_addr", 0, 32'(addr[0]), 32'd4);
        chk("set_wdata", 0, 32'(wd[0]), 32'd1);
        @(negedge clk);
        chk("set_shadow", 0, 32'(shadow[0]), 32'd1);
        @(posedge clk);
        wait_acc(0, t2);
        #1 cmd_valid[0] = 1'b0;
        chk("clr_accept_gap", 0, 32'(t2 - t1), 32'd3);
        at_cyc(t2 + 1);
        chk("clr_addr", 0, 32'(addr[0]), 32'd5);
        chk("clr_wdata", 0, 32'(wd[0]), 32'd1);
        at_cyc(t2 + 2);
        chk("clr_shadow", 0, 32'(shadow[0]), 32'd0);

        // READ, latency 0, slave returns 1 with shadow 1
        issue(0, OP_W, 1'b1, t);
        issue(0, OP_R, 1'b0, t);
        at_cyc(t + 2);
        chk("rd0_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
        chk("rd0_data", 0, 32'(rsp_data[0]), 32'd1);
        chk("rd0_mismatch", 0, 32'(rsp_mis[0]), 32'd0);

        // READ, latency 2, slave forced to 0 with shadow 1
        issue(1, OP_W, 1'b1, t);
        @(posedge clk); #1 ovr_en[1] = 1'b1; ovr_val[1] = '0;
        issue(1, OP_R, 1'b0, t);
        at_cyc(t + 1);
        chk("rd2_cs_issue", 1, 32'(cs[1]), 32'd1);
        at_cyc(t + 2);
        chk("rd2_cs_wait", 1, 32'(cs[1]), 32'd0);
        at_cyc(t + 3);
        chk("rd2_rsp_early", 1, 32'(rsp_valid[1]), 32'd0);
        at_cyc(t + 4);
        chk("rd2_rsp_valid", 1, 32'(rsp_valid[1]), 32'd1);
        chk("rd2_data", 1, 32'(rsp_data[1]), 32'd0);
        chk("rd2_mismatch", 1, 32'(rsp_mis[1]), 32'd1);
        chk("rd2_shadow", 1, 32'(shadow[1]), 32'd0);
        @(posedge clk); #1 ovr_en[1] = 1'b0;

        // Reset during WAIT of a latency-3 read
        issue(2, OP_W, 1'b1, t);
        issue(2, OP_R, 1'b0, t);
        at_cyc(t + 3);
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_cs", 2, 32'(cs[2]), 32'd0);
        chk("rstw_write_n", 2, 32'(wn[2]), 32'd1);
        chk("rstw_rsp_valid", 2, 32'(rsp_valid[2]), 32'd0);
        chk("rstw_shadow", 2, 32'(shadow[2]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstw_no_rsp", 2, 32'(rsp_valid[2]), 32'd0);
        end
        chk("rstw_ready", 2, 32'(cmd_ready[2]), 32'd1);

        // Real PIO: WRITE 1, READ, CLEAR, READ
        issue(0, OP_W, 1'b1, t);
        issue(0, OP_R, 1'b0, t);
        at_cyc(t + 2);
        chk("pio_rd1_data", 0, 32'(rsp_data[0]), 32'd1);
        chk("pio_rd1_mis", 0, 32'(rsp_mis[0]), 32'd0);
        issue(0, OP_C, 1'b0, t);
        issue(0, OP_R, 1'b0, t);
        at_cyc(t + 2);
        chk("pio_rd2_data", 0, 32'(rsp_data[0]), 32'd0);
        chk("pio_rd2_mis", 0, 32'(rsp_mis[0]), 32'd0);

        // SET then READ through latency-2 instance
        issue(1, OP_S, 1'b0, t);
        issue(1, OP_R, 1'b0, t);
        at_cyc(t + 4);
        chk("set_rd_valid", 1, 32'(rsp_valid[1]), 32'd1);
        chk("set_rd_data", 1, 32'(rsp_data[1]), 32'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
